// File: rtl/alu_addsub_arbiter.sv
// Two-requester round-robin front end for a shared external adder/subtracter.
// One operation in flight; IDLE -> ISSUE -> CAPTURE -> RESP.
module alu_addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  input  logic             r0_sub,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_ready,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  input  logic             r1_valid,
  input  logic             r1_sub,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_ready,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ctrl,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_zero,
  input  logic             add_ovf,
  input  logic             add_neg,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_neg,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_last;
  logic             r_gid;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_ctrl;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_neg;

  logic w_idle;
  logic w_pick1;
  logic w_acc;
  logic w_done;

  assign w_idle  = (r_state == S_IDLE);
  // r1 wins alone, or on a tie when r0 had the last grant
  assign w_pick1 = r1_valid && (!r0_valid || !r_last);
  assign w_acc   = w_idle && (r0_valid || r1_valid);
  assign w_done  = (r_state == S_RESP) &&
                   (r_gid ? r1_rsp_ready : r0_rsp_ready);

  assign r0_ready = w_idle && r0_valid && !w_pick1;
  assign r1_ready = w_idle && w_pick1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = S_ISSUE;
      S_ISSUE: w_next = S_CAPT;
      S_CAPT:  w_next = S_RESP;
      S_RESP:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_gid      <= 1'b0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_ctrl <= 1'b0;
    end else if (w_acc) begin
      r_last     <= w_pick1;
      r_gid      <= w_pick1;
      r_add_a    <= w_pick1 ? r1_a : r0_a;
      r_add_b    <= w_pick1 ? r1_b : r0_b;
      r_add_ctrl <= w_pick1 ? r1_sub : r0_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_sum  <= add_sum;
      r_cout <= add_cout;
      r_zero <= add_zero;
      r_ovf  <= add_ovf;
      r_neg  <= add_neg;
    end
  end

  assign r0_rsp_valid = (r_state == S_RESP) && !r_gid;
  assign r1_rsp_valid = (r_state == S_RESP) && r_gid;

  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign add_ctrl = r_add_ctrl;
  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_zero = r_zero;
  assign rsp_ovf  = r_ovf;
  assign rsp_neg  = r_neg;
  assign busy     = !w_idle;
  assign grant_id = r_gid;

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Scoreboard bench for alu_addsub_arbiter with a behavioural adder
// hooked to the add_* ports.
module tb_alu_addsub_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r0_sub, r0_ready;
  logic         r0_rsp_valid, r0_rsp_ready;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_sub, r1_ready;
  logic         r1_rsp_valid, r1_rsp_ready;
  logic [W-1:0] r1_a, r1_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_ctrl, add_cout, add_zero, add_ovf, add_neg;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_zero, rsp_ovf, rsp_neg;
  logic         busy, grant_id;

  alu_addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_sub(r0_sub),
    .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_valid(r1_valid), .r1_sub(r1_sub),
    .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl),
    .add_sum(add_sum), .add_cout(add_cout),
    .add_zero(add_zero), .add_ovf(add_ovf), .add_neg(add_neg),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_neg(rsp_neg),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // external adder: A + (B ^ ctrl) + ctrl
  logic [W-1:0] w_bb;
  logic [W:0]   w_full;
  always_comb begin
    w_bb     = add_ctrl ? ~add_b : add_b;
    w_full   = {1'b0, add_a} + {1'b0, w_bb} + {{W{1'b0}}, add_ctrl};
    add_sum  = w_full[W-1:0];
    add_cout = w_full[W];
    add_zero = (w_full[W-1:0] == '0);
    add_neg  = w_full[W-1];
    add_ovf  = (add_a[W-1] == w_bb[W-1]) && (w_full[W-1] != add_a[W-1]);
  end

  typedef struct {
    bit           id;
    logic [W-1:0] s;
    bit           c, z, v, n;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_rv = 0;
  logic [W-1:0] l_sum;
  logic l_c, l_z, l_v, l_n, l_gid;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // arithmetic-level reference, independent of the adder formulation
  function automatic exp_t model(bit id, bit sub,
                                 logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    int ia, ib, r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    r  = sub ? ia - ib : ia + ib;
    e.id = id;
    e.s  = sub ? a - b : a + b;
    e.c  = sub ? (a >= b) : ((int'(a) + int'(b)) > 255);
    e.v  = (r > 127) || (r < -128);
    e.z  = (e.s == 0);
    e.n  = e.s[W-1];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit   rv;
    exp_t e;
    if (rst_n) begin
      chk("ready_excl", {31'b0, r0_ready & r1_ready}, 0);
      if (busy) chk("ready_busy", {31'b0, r0_ready | r1_ready}, 0);
      if (r0_ready && r0_valid) begin
        sb.push_back(model(0, r0_sub, r0_a, r0_b));
        grants.push_back(0);
        acc_cyc = cyc + 1;
      end
      if (r1_ready && r1_valid) begin
        sb.push_back(model(1, r1_sub, r1_a, r1_b));
        grants.push_back(1);
        acc_cyc = cyc + 1;
      end
      rv = r0_rsp_valid | r1_rsp_valid;
      if (rv && !prev_rv) chk("rsp_latency", cyc - acc_cyc, 2);
      if (rv) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          e = sb[0];
          chk("rsp_sum", rsp_sum, e.s);
          chk("rsp_cout", rsp_cout, e.c);
          chk("rsp_zero", rsp_zero, e.z);
          chk("rsp_ovf", rsp_ovf, e.v);
          chk("rsp_neg", rsp_neg, e.n);
          chk("rsp_owner", {r1_rsp_valid, r0_rsp_valid}, e.id ? 2 : 1);
          chk("grant_id", grant_id, e.id);
          if (e.id ? r1_rsp_ready : r0_rsp_ready) begin
            void'(sb.pop_front());
            l_sum = rsp_sum; l_c = rsp_cout; l_z = rsp_zero;
            l_v = rsp_ovf; l_n = rsp_neg; l_gid = grant_id;
            n_rsp++;
          end
        end
      end
      prev_rv = rv;
    end else begin
      prev_rv = 0;
    end
  end

  task automatic do_req(input bit id, input bit sub,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    if (id) begin
      r1_valid = 1; r1_sub = sub; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1; r0_sub = sub; r0_a = a; r0_b = b;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = id ? r1_ready : r0_ready;
    end
    if (!got) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) r1_valid = 0;
    else r0_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 40 && n_rsp < target; i++) @(negedge clk);
    if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 0;
    r0_valid = 0; r0_sub = 0; r0_a = 0; r0_b = 0; r0_rsp_ready = 1;
    r1_valid = 0; r1_sub = 0; r1_a = 0; r1_b = 0; r1_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_grant", grant_id, 0);
    rst_n = 1;
    @(posedge clk); #1;

    do_req(0, 0, 8'h05, 8'h03);
    wait_rsp(1);
    chk("t2_sum", l_sum, 8'h08);
    chk("t2_cout", l_c, 0);
    chk("t2_zero", l_z, 0);

    do_req(1, 1, 8'h10, 8'h10);
    wait_rsp(2);
    chk("t3_sum", l_sum, 8'h00);
    chk("t3_zero", l_z, 1);
    chk("t3_cout", l_c, 1);
    chk("t3_gid", l_gid, 1);

    do_req(0, 0, 8'h7F, 8'h01);
    wait_rsp(3);
    chk("t4_sum", l_sum, 8'h80);
    chk("t4_ovf", l_v, 1);
    chk("t4_neg", l_n, 1);

    // abort mid-RESP
    r1_rsp_ready = 0;
    do_req(1, 0, 8'h33, 8'h44);
    for (int i = 0; i < 20 && !r1_rsp_valid; i++) @(negedge clk);
    chk("t1_in_resp", r1_rsp_valid, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t1_rspv", {r0_rsp_valid, r1_rsp_valid}, 0);
    chk("t1_busy", busy, 0);
    chk("t1_add", {add_a, add_b, 7'b0, add_ctrl}, 0);
    chk("t1_rsp", {rsp_sum, rsp_cout, rsp_zero, rsp_ovf, rsp_neg}, 0);
    chk("t1_gid", grant_id, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    r1_rsp_ready = 1;
    @(posedge clk); #1;

    grants.delete();
    base = n_rsp;
    fork
      begin
        do_req(0, 0, 8'h01, 8'h02);
        do_req(0, 1, 8'h00, 8'h01);
      end
      begin
        do_req(1, 0, 8'hF0, 8'h20);
        do_req(1, 1, 8'h80, 8'h01);
      end
    join
    wait_rsp(base + 4);
    chk("t5_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk($sformatf("t5_grant%0d", i), grants[i], i % 2);
    end

    r0_rsp_ready = 0;
    base = n_rsp;
    do_req(0, 1, 8'h20, 8'h05);
    r1_valid = 1; r1_sub = 0; r1_a = 8'h11; r1_b = 8'h22;
    for (int i = 0; i < 20 && !r0_rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_v", r0_rsp_valid, 1);
      chk("t6_hold_sum", rsp_sum, 8'h1B);
      chk("t6_r1_ready", r1_ready, 0);
    end
    @(posedge clk); #1;
    r0_rsp_ready = 1;
    for (int i = 0; i < 20 && !r1_ready; i++) @(negedge clk);
    chk("t6_r1_late", r1_ready, 1);
    chk("t6_r0_done", n_rsp, base + 1);
    @(posedge clk); #1;
    r1_valid = 0;
    wait_rsp(base + 2);
    chk("t6_r1_sum", l_sum, 8'h33);
    chk("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
